// File: rtl/qstate_pair_sequencer_pkg.sv
// qstate_pair_sequencer_pkg: fixed-point format, reset amplitude, state encoding and pair-index helper
package qstate_pair_sequencer_pkg;

   // Q-format shared with the gate datapath (fixed_point_params values)
   localparam int TOTAL_WIDTH = 16;
   localparam int FRAC_WIDTH  = 4;

   // 1.0 in the amplitude format, used to reset the state to |000>
   localparam logic signed [TOTAL_WIDTH-1:0] QS_ONE = TOTAL_WIDTH'(1 << FRAC_WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   typedef struct packed {
      logic signed [TOTAL_WIDTH-1:0] re;
      logic signed [TOTAL_WIDTH-1:0] im;
   } qs_cplx_t;

   // Index of the pair's low element: k with a 0 spliced in at bit position t
   function automatic int insert_zero(input int k, input int t);
      int m;
      m = (1 << t) - 1;
      return ((k & ~m) << 1) | (k & m);
   endfunction

endpackage

// File: rtl/qstate_pair_sequencer_mem.sv
// qstate_mem: N-entry complex register file with a dual-address write port, two pair-read ports and a read port
module qstate_mem
   import qstate_pair_sequencer_pkg::*;
#(
   parameter int NQ = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic          wr_dual_i,
   input  logic [NQ-1:0] wa_addr_i,
   input  logic [NQ-1:0] wb_addr_i,
   input  qs_cplx_t      wa_data_i,
   input  qs_cplx_t      wb_data_i,
   input  logic [NQ-1:0] pa_addr_i,
   input  logic [NQ-1:0] pb_addr_i,
   input  logic [NQ-1:0] rd_addr_i,
   output qs_cplx_t      pa_data_o,
   output qs_cplx_t      pb_data_o,
   output qs_cplx_t      rd_data_o
);
   localparam int N = 2**NQ;

   qs_cplx_t mem_q [N];

   // Reset to |000>; a pair write lands both halves on the same edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int j = 0; j < N; j++)
            mem_q[j] <= '0;
         mem_q[0] <= {QS_ONE, {TOTAL_WIDTH{1'b0}}};
      end else if (wr_en_i) begin
         mem_q[wa_addr_i] <= wa_data_i;
         if (wr_dual_i)
            mem_q[wb_addr_i] <= wb_data_i;
      end

   assign pa_data_o = mem_q[pa_addr_i];
   assign pb_data_o = mem_q[pb_addr_i];
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/qstate_pair_sequencer.sv
// qstate_pair_sequencer: streams butterfly pairs of a 3-qubit state into an external H gate and writes results back.
// Define QSTATE_MAG_EN to add the squared-magnitude read output rd_mag_o.
module qstate_pair_sequencer
   import qstate_pair_sequencer_pkg::*;
#(
   parameter int NQ       = 3,
   parameter int GATE_LAT = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ld_we_i,
   input  logic [NQ-1:0]                 ld_addr_i,
   input  logic signed [TOTAL_WIDTH-1:0] ld_r_i,
   input  logic signed [TOTAL_WIDTH-1:0] ld_i_i,
   input  logic                          start_i,
   input  logic [1:0]                    target_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   input  logic [NQ-1:0]                 rd_addr_i,
   output logic signed [TOTAL_WIDTH-1:0] rd_r_o,
   output logic signed [TOTAL_WIDTH-1:0] rd_i_o,
   output logic signed [TOTAL_WIDTH-1:0] g_alpha_r_o,
   output logic signed [TOTAL_WIDTH-1:0] g_alpha_i_o,
   output logic signed [TOTAL_WIDTH-1:0] g_beta_r_o,
   output logic signed [TOTAL_WIDTH-1:0] g_beta_i_o,
   input  logic signed [TOTAL_WIDTH-1:0] g_new_alpha_r_i,
   input  logic signed [TOTAL_WIDTH-1:0] g_new_alpha_i_i,
   input  logic signed [TOTAL_WIDTH-1:0] g_new_beta_r_i,
   input  logic signed [TOTAL_WIDTH-1:0] g_new_beta_i_i
`ifdef QSTATE_MAG_EN
   ,
   output logic [2*TOTAL_WIDTH-1:0]      rd_mag_o
`endif
);
   localparam int N  = 2**NQ;
   localparam int NP = N / 2;
   localparam int KW = NQ - 1;

   logic [1:0]        state_q, state_d;
   logic [1:0]        t_q, t_d;
   logic [KW-1:0]     k_q, k_d;
   logic              busy_q, busy_d;
   logic              errp_q, errp_d;
   logic              done_q, err_q;
   logic [GATE_LAT:0] tag_v_q;
   logic [NQ-1:0]     tag_lo_q [GATE_LAT+1];
   logic [NQ-1:0]     tag_hi_q [GATE_LAT+1];
   qs_cplx_t          g_a_q, g_b_q;
   qs_cplx_t          pa, pb, rd, wa_data, wb_data;
   logic [NQ-1:0]     lo, hi, wa_addr;
   logic              issue, wb, ld, tgt_ok, k_last, pipe_drained;

   assign lo           = NQ'(insert_zero(int'(k_q), int'(t_q)));
   assign hi           = lo | (NQ'(1) << t_q);
   assign issue        = state_q == S_ISSUE;
   assign tgt_ok       = int'(target_i) < NQ;
   assign k_last       = k_q == KW'(NP - 1);
   // The pair still in the last gate stage is written on the edge that leaves FIN,
   // so done can follow the final write-back directly
   assign pipe_drained = tag_v_q[GATE_LAT-2:0] == '0;

   // Write-back owns the port while a tagged result emerges; loads only while idle
   assign wb      = tag_v_q[GATE_LAT];
   assign ld      = ld_we_i & ~busy_q;
   assign wa_addr = wb ? tag_lo_q[GATE_LAT] : ld_addr_i;
   assign wa_data = wb ? {g_new_alpha_r_i, g_new_alpha_i_i} : {ld_r_i, ld_i_i};
   assign wb_data = {g_new_beta_r_i, g_new_beta_i_i};

   qstate_mem #(.NQ(NQ)) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wb | ld),
      .wr_dual_i (wb),
      .wa_addr_i (wa_addr),
      .wb_addr_i (tag_hi_q[GATE_LAT]),
      .wa_data_i (wa_data),
      .wb_data_i (wb_data),
      .pa_addr_i (lo),
      .pb_addr_i (hi),
      .rd_addr_i (rd_addr_i),
      .pa_data_o (pa),
      .pb_data_o (pb),
      .rd_data_o (rd)
   );

   // Sequencer: accept start, walk the pairs, wait for the gate, then report
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      k_d     = k_q;
      busy_d  = busy_q;
      errp_d  = errp_q;
      case (state_q)
         S_IDLE:
            if (start_i) begin
               state_d = tgt_ok ? S_ISSUE : S_FIN;
               t_d     = tgt_ok ? target_i : t_q;
               k_d     = '0;
               busy_d  = tgt_ok;
               errp_d  = ~tgt_ok;
            end
         S_ISSUE: begin
            k_d     = k_q + KW'(1);
            state_d = k_last ? S_DRAIN : S_ISSUE;
         end
         S_DRAIN: state_d = pipe_drained ? S_FIN : S_DRAIN;
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            errp_d  = 1'b0;
         end
      endcase
   end

   // Control state and the one-cycle done/err pulses that follow FIN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         errp_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         errp_q  <= errp_d;
         done_q  <= state_q == S_FIN;
         err_q   <= (state_q == S_FIN) & errp_q;
      end

   // Present the current pair to the gate; outputs rest at zero otherwise
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         g_a_q <= '0;
         g_b_q <= '0;
      end else begin
         g_a_q <= issue ? pa : '0;
         g_b_q <= issue ? pb : '0;
      end

   // Tag pipe tracks each pair's addresses alongside the gate latency
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tag_v_q <= '0;
         for (int j = 0; j <= GATE_LAT; j++) begin
            tag_lo_q[j] <= '0;
            tag_hi_q[j] <= '0;
         end
      end else begin
         tag_v_q     <= {tag_v_q[GATE_LAT-1:0], issue};
         tag_lo_q[0] <= lo;
         tag_hi_q[0] <= hi;
         for (int j = 1; j <= GATE_LAT; j++) begin
            tag_lo_q[j] <= tag_lo_q[j-1];
            tag_hi_q[j] <= tag_hi_q[j-1];
         end
      end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rd_r_o      = rd.re;
   assign rd_i_o      = rd.im;
   assign g_alpha_r_o = g_a_q.re;
   assign g_alpha_i_o = g_a_q.im;
   assign g_beta_r_o  = g_b_q.re;
   assign g_beta_i_o  = g_b_q.im;

`ifdef QSTATE_MAG_EN
   logic signed [2*TOTAL_WIDTH-1:0] sq_r, sq_i;

   // Squared magnitude of the read port, 2*FRAC_WIDTH fraction bits
   assign sq_r     = rd.re * rd.re;
   assign sq_i     = rd.im * rd.im;
   assign rd_mag_o = $unsigned(sq_r) + $unsigned(sq_i);
`endif

endmodule

// File: tb/tb_qstate_pair_sequencer.sv
// tb_qstate_pair_sequencer: scoreboard bench with an external H gate model and a state-vector reference
module tb_qstate_pair_sequencer;

   typedef struct packed {
      logic             err;
      int               t0;
      int               lat;
      logic [7:0][15:0] r;
      logic [7:0][15:0] im;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_we_i, start_i;
   logic [2:0]        ld_addr_i, rd_addr_i;
   logic signed [15:0] ld_r_i, ld_i_i;
   logic [1:0]        target_i;
   logic              busy_o, done_o, err_o;
   logic signed [15:0] rd_r_o, rd_i_o;
   logic signed [15:0] g_alpha_r_o, g_alpha_i_o, g_beta_r_o, g_beta_i_o;
   logic signed [15:0] g_new_alpha_r_i, g_new_alpha_i_i, g_new_beta_r_i, g_new_beta_i_i;
`ifdef QSTATE_MAG_EN
   logic [31:0]       rd_mag_o;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic mon_busy;
   exp_t sb[$];
   exp_t chkq[$];
   int   mr[8];
   int   mi[8];

   qstate_pair_sequencer #(.NQ(3), .GATE_LAT(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ld_we_i         (ld_we_i),
      .ld_addr_i       (ld_addr_i),
      .ld_r_i          (ld_r_i),
      .ld_i_i          (ld_i_i),
      .start_i         (start_i),
      .target_i        (target_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .rd_addr_i       (rd_addr_i),
      .rd_r_o          (rd_r_o),
      .rd_i_o          (rd_i_o),
      .g_alpha_r_o     (g_alpha_r_o),
      .g_alpha_i_o     (g_alpha_i_o),
      .g_beta_r_o      (g_beta_r_o),
      .g_beta_i_o      (g_beta_i_o),
      .g_new_alpha_r_i (g_new_alpha_r_i),
      .g_new_alpha_i_i (g_new_alpha_i_i),
      .g_new_beta_r_i  (g_new_beta_r_i),
      .g_new_beta_i_i  (g_new_beta_i_i)
`ifdef QSTATE_MAG_EN
      ,
      .rd_mag_o        (rd_mag_o)
`endif
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hadamard scaling: x / sqrt(2) with 1/sqrt(2) ~ 11/16
   function automatic logic signed [15:0] hs(input int x);
      return 16'((x * 11) >>> 4);
   endfunction

   // External 3-stage H gate
   logic signed [15:0] p_ar[3], p_ai[3], p_br[3], p_bi[3];
   always @(posedge clk) begin
      p_ar[0] <= hs(int'(g_alpha_r_o) + int'(g_beta_r_o));
      p_ai[0] <= hs(int'(g_alpha_i_o) + int'(g_beta_i_o));
      p_br[0] <= hs(int'(g_alpha_r_o) - int'(g_beta_r_o));
      p_bi[0] <= hs(int'(g_alpha_i_o) - int'(g_beta_i_o));
      for (int s = 1; s < 3; s++) begin
         p_ar[s] <= p_ar[s-1];
         p_ai[s] <= p_ai[s-1];
         p_br[s] <= p_br[s-1];
         p_bi[s] <= p_bi[s-1];
      end
   end
   assign g_new_alpha_r_i = p_ar[2];
   assign g_new_alpha_i_i = p_ai[2];
   assign g_new_beta_r_i  = p_br[2];
   assign g_new_beta_i_i  = p_bi[2];

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int rv();
      return int'($urandom_range(0, 4000)) - 2000;
   endfunction

   // Reference: apply H to every pair whose index differs only in bit t
   function automatic void model_h(input int t);
      int j, ar, br, ai, bi;
      for (int i = 0; i < 8; i++)
         if (((i >> t) & 1) == 0) begin
            j = i | (1 << t);
            ar = mr[i]; br = mr[j]; ai = mi[i]; bi = mi[j];
            mr[i] = int'(hs(ar + br));
            mr[j] = int'(hs(ar - br));
            mi[i] = int'(hs(ai + bi));
            mi[j] = int'(hs(ai - bi));
         end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         mr[i] = 0;
         mi[i] = 0;
      end
      mr[0] = 16;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e = '0;
      for (int i = 0; i < 8; i++) begin
         e.r[i]  = 16'(mr[i]);
         e.im[i] = 16'(mi[i]);
      end
      return e;
   endfunction

   task automatic sweep(input exp_t e);
      longint vr, vi;
      for (int a = 0; a < 8; a++) begin
         rd_addr_i = a[2:0];
         #1;
         vr = longint'($signed(e.r[a]));
         vi = longint'($signed(e.im[a]));
         chk($sformatf("mem_r[%0d]", a), longint'(rd_r_o), vr);
         chk($sformatf("mem_i[%0d]", a), longint'(rd_i_o), vi);
`ifdef QSTATE_MAG_EN
         chk($sformatf("mag[%0d]", a), longint'(rd_mag_o), vr * vr + vi * vi);
`endif
      end
   endtask

   // Monitor: pops an expectation whenever done pulses, or sweeps on request while idle
   initial begin
      exp_t e;
      mon_busy  = 1'b0;
      rd_addr_i = '0;
      forever begin
         @(negedge clk);
         if (done_o) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done at cycle %0d", cyc);
            end else begin
               mon_busy = 1'b1;
               e = sb.pop_front();
               chk("err_with_done", longint'(err_o), longint'(e.err));
               chk("start_to_done", longint'(cyc - e.t0), longint'(e.lat));
               chk("busy_at_done", longint'(busy_o), 0);
               sweep(e);
               mon_busy = 1'b0;
            end
         end else begin
            if (err_o) begin
               checks++;
               errors++;
               $display("FAIL err_without_done at cycle %0d", cyc);
            end
            if (chkq.size() != 0) begin
               mon_busy = 1'b1;
               e = chkq.pop_front();
               sweep(e);
               mon_busy = 1'b0;
            end
         end
      end
   end

   task automatic load(input int a, input int r, input int i);
      @(negedge clk);
      ld_we_i = 1'b1; ld_addr_i = a[2:0]; ld_r_i = r[15:0]; ld_i_i = i[15:0];
      mr[a] = r; mi[a] = i;
      @(posedge clk); #1;
      ld_we_i = 1'b0;
   endtask

   task automatic issue(input bit sync, input int tgt, input bit wl, input int la, input int lr, input int li);
      exp_t e;
      if (sync) @(negedge clk);
      start_i = 1'b1; target_i = tgt[1:0];
      if (wl) begin
         ld_we_i = 1'b1; ld_addr_i = la[2:0]; ld_r_i = lr[15:0]; ld_i_i = li[15:0];
         mr[la] = lr; mi[la] = li;
      end
      @(posedge clk); #1;
      start_i = 1'b0; ld_we_i = 1'b0;
      if (tgt >= 3) begin
         chk("busy_on_err", longint'(busy_o), 0);
      end else begin
         model_h(tgt);
      end
      e     = snap();
      e.err = tgt >= 3;
      e.lat = (tgt >= 3) ? 1 : 4 + 3 + 1;
      e.t0  = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while ((sb.size() != 0 || chkq.size() != 0 || mon_busy) && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) begin
         errors++;
         $display("FAIL timeout waiting for done actual=%0d required=0 pending", sb.size());
         sb.delete();
         chkq.delete();
      end
   endtask

   task automatic check_quiet(input string nm);
      chk({nm, "_busy"}, longint'(busy_o), 0);
      chk({nm, "_done"}, longint'(done_o), 0);
      chk({nm, "_g"}, longint'(g_alpha_r_o | g_alpha_i_o | g_beta_r_o | g_beta_i_o), 0);
   endtask

   // Global bound
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int cnt, c;
      rst_n = 1'b0; ld_we_i = 1'b0; start_i = 1'b0; target_i = '0;
      ld_addr_i = '0; ld_r_i = '0; ld_i_i = '0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      chk("reset_err", longint'(err_o), 0);
      rst_n = 1'b1;
      model_reset();
      chkq.push_back(snap());
      wait_idle();

      // H on qubit 0 from |000>
      issue(1, 0, 0, 0, 0, 0);
      wait_idle();

      // H on qubit 2 of 1.0|000> + 1.0|100>
      for (int a = 0; a < 8; a++) load(a, (a == 0 || a == 4) ? 16 : 0, 0);
      issue(1, 2, 0, 0, 0, 0);
      wait_idle();

      // Start and load while busy are ignored
      issue(1, 1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("busy_mid", longint'(busy_o), 1);
      start_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 3'd3; ld_r_i = 16'sd5; ld_i_i = '0;
      @(negedge clk);
      start_i = 1'b0; ld_we_i = 1'b0;
      wait_idle();

      // Out-of-range target
      issue(1, 3, 0, 0, 0, 0);
      wait_idle();

      // Back-to-back start in the done cycle, with a load on the second start
      issue(1, 1, 0, 0, 0, 0);
      c = 0;
      while (!done_o && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (!done_o) begin
         errors++;
         $display("FAIL b2b_done_wait actual=0 required=1");
      end
      issue(0, 0, 1, 6, 300, -200);
      wait_idle();

      // Randomised loads, targets and load-with-start
      for (int n = 0; n < 16; n++) begin
         cnt = int'($urandom_range(0, 3));
         for (int q = 0; q < cnt; q++) load(int'($urandom_range(0, 7)), rv(), rv());
         issue(1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), rv(), rv());
         wait_idle();
      end

      // Reset mid-operation, then rerun H on qubit 0
      @(negedge clk);
      start_i = 1'b1; target_i = 2'd0;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_quiet("abort");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chkq.push_back(snap());
      wait_idle();
      issue(1, 0, 0, 0, 0, 0);
      wait_idle();

      repeat (12) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
